// File: rtl/corefifo_rd_ctrl.sv
// Read-side pointer and flag controller of the dual-clock FIFO (read clock domain).
// Synchronises the Gray write pointer, tracks the read pointer and drives empty/aempty/count/dvld.
module corefifo_rd_ctrl #(
    parameter int ADDRWIDTH     = 3,
    parameter int AEMPTY_THRESH = 1,
    parameter int RD_LATENCY    = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [ADDRWIDTH:0]   wptr_gray,
    input  logic                 re,
    output logic                 ram_re,
    output logic [ADDRWIDTH-1:0] raddr,
    output logic [ADDRWIDTH:0]   rptr_gray,
    output logic                 empty,
    output logic                 aempty,
    output logic [ADDRWIDTH:0]   rd_count,
    output logic                 dvld,
    output logic                 underflow
);

    localparam int            PW    = ADDRWIDTH + 1;
    localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_THRESH);

    logic [PW-1:0]         wsync1_q, wsync2_q, wptr_bin;
    logic [PW-1:0]         rptr_bin_q, rptr_bin_d;
    logic [PW-1:0]         rptr_gray_q, rptr_gray_d;
    logic [PW-1:0]         rd_count_q, rd_count_d;
    logic                  empty_q, empty_d;
    logic                  aempty_q, aempty_d;
    logic                  underflow_q, underflow_d;
    logic [RD_LATENCY-1:0] dvld_q, dvld_d;
    logic                  rd_ok;

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        wptr_bin = '0;
        for (int i = 0; i < PW; i++) begin
            wptr_bin[i] = ^(wsync2_q >> i);
        end
    end

    always_comb begin
        // NOTE: every signal gets a value before any condition, so no latch can be inferred.
        rd_ok       = re & ~empty_q;
        rptr_bin_d  = rptr_bin_q + PW'(rd_ok);
        rptr_gray_d = rptr_bin_d ^ (rptr_bin_d >> 1);
        rd_count_d  = wptr_bin - rptr_bin_d;
        empty_d     = (wptr_bin == rptr_bin_d);
        aempty_d    = (rd_count_d <= AE_TH);
        underflow_d = re & empty_q;
        dvld_d      = RD_LATENCY'({dvld_q, rd_ok});
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (RESET) begin
            wsync1_q    <= '0;
            wsync2_q    <= '0;
            rptr_bin_q  <= '0;
            rptr_gray_q <= '0;
            rd_count_q  <= '0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            underflow_q <= 1'b0;
            dvld_q      <= '0;
        end else begin
            wsync1_q    <= wptr_gray;
            wsync2_q    <= wsync1_q;
            rptr_bin_q  <= rptr_bin_d;
            rptr_gray_q <= rptr_gray_d;
            rd_count_q  <= rd_count_d;
            empty_q     <= empty_d;
            aempty_q    <= aempty_d;
            underflow_q <= underflow_d;
            dvld_q      <= dvld_d;
        end
    end

    assign ram_re    = rd_ok;
    assign raddr     = rptr_bin_q[ADDRWIDTH-1:0];
    assign rptr_gray = rptr_gray_q;
    assign empty     = empty_q;
    assign aempty    = aempty_q;
    assign rd_count  = rd_count_q;
    assign dvld      = dvld_q[RD_LATENCY-1];
    assign underflow = underflow_q;

endmodule

// File: tb/tb_corefifo_rd_ctrl.sv
// Self-checking bench for corefifo_rd_ctrl: word-count reference model with a two-edge
// visibility lag on writes, driven by directed sequences and randomized traffic.
module tb_corefifo_rd_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       re;
    logic [3:0] wptr_gray;
    logic       ram_re;
    logic [2:0] raddr;
    logic [3:0] rptr_gray;
    logic       empty, aempty;
    logic [3:0] rd_count;
    logic       dvld, underflow;

    always #5 CLK = ~CLK;

    corefifo_rd_ctrl #(.ADDRWIDTH(3), .AEMPTY_THRESH(1), .RD_LATENCY(1)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .wptr_gray (wptr_gray),
        .re        (re),
        .ram_re    (ram_re),
        .raddr     (raddr),
        .rptr_gray (rptr_gray),
        .empty     (empty),
        .aempty    (aempty),
        .rd_count  (rd_count),
        .dvld      (dvld),
        .underflow (underflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: total words written/read, and written totals seen at the last two edges.
    int   wr_total, rd_total, wr_d1, wr_d2;
    int   exp_count;
    logic exp_empty, exp_aempty, exp_dvld, exp_uf;

    function automatic logic [3:0] to_gray(input int n);
        logic [3:0] b;
        b = 4'(n % 16);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        wr_total   = 0;
        rd_total   = 0;
        wr_d1      = 0;
        wr_d2      = 0;
        exp_count  = 0;
        exp_empty  = 1'b1;
        exp_aempty = 1'b1;
        exp_dvld   = 1'b0;
        exp_uf     = 1'b0;
    endtask

    // One clock cycle: drive inputs, check all outputs mid-cycle, then advance the model.
    task automatic cycle(input logic r, input logic rst, input logic wr);
        int   vis;
        logic ok;
        if (wr) wr_total++;
        wptr_gray = to_gray(wr_total);
        re        = r;
        RESET     = rst;
        @(negedge CLK);
        check("ram_re",    32'(ram_re),    32'(r && !exp_empty));
        check("raddr",     32'(raddr),     32'(rd_total % 8));
        check("rptr_gray", 32'(rptr_gray), 32'(to_gray(rd_total)));
        check("empty",     32'(empty),     32'(exp_empty));
        check("aempty",    32'(aempty),    32'(exp_aempty));
        check("rd_count",  32'(rd_count),  32'(exp_count));
        check("dvld",      32'(dvld),      32'(exp_dvld));
        check("underflow", 32'(underflow), 32'(exp_uf));
        @(posedge CLK);
        if (rst) begin
            model_reset();
        end else begin
            ok        = r && !exp_empty;
            exp_uf    = r && exp_empty;
            exp_dvld  = ok;
            rd_total += int'(ok);
            vis       = wr_d2;
            wr_d2     = wr_d1;
            wr_d1     = wr_total;
            exp_count = vis - rd_total;
            exp_empty  = (exp_count == 0);
            exp_aempty = (exp_count <= 1);
        end
        #1;
    endtask

    logic [3:0] gseq [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                             4'b0111, 4'b0101, 4'b0100, 4'b1100};

    initial begin
        logic r, w;
        int   guard;
        RESET     = 1'b1;
        re        = 1'b0;
        wptr_gray = '0;
        @(posedge CLK);
        #1;
        model_reset();

        // Reset state, then first word through the synchroniser and a single read.
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        check("lat_2edges_empty", 32'(empty), 32'd1);
        cycle(1'b0, 1'b0, 1'b0);
        check("lat_3edges_empty", 32'(empty), 32'd0);
        check("lat_3edges_count", 32'(rd_count), 32'd1);
        cycle(1'b1, 1'b0, 1'b0);
        check("t2_rptr_gray", 32'(rptr_gray), 32'b0001);
        check("t2_dvld",      32'(dvld),      32'd1);
        check("t2_empty",     32'(empty),     32'd1);

        // Fill to 8 words, then drain with back-to-back reads.
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
        check("t3_full_count",  32'(rd_count), 32'd8);
        check("t3_full_aempty", 32'(aempty),   32'd0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            check($sformatf("t3_gray_%0d", i), 32'(rptr_gray), 32'(gseq[i]));
        end
        check("t3_empty_after_8", 32'(empty), 32'd1);

        // Random traffic over 40+ words so both pointers wrap twice.
        guard = 0;
        while (wr_total < 49 && guard < 2000) begin
            w = ($urandom_range(0, 1) == 1) && (wr_total - rd_total < 8);
            r = ($urandom_range(0, 2) != 0);
            cycle(r, 1'b0, w);
            guard++;
        end

        // Drain, then keep reading while empty to exercise underflow.
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0);
        check("t5_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            check("t5_underflow", 32'(underflow), 32'd1);
            check("t5_no_dvld",   32'(dvld),      32'd0);
        end
        cycle(1'b0, 1'b0, 1'b0);

        // Reset while 5 words are available and a read is being accepted.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
        check("t6_count5", 32'(rd_count), 32'd5);
        cycle(1'b1, 1'b1, 1'b0);
        check("t6_dvld",     32'(dvld),      32'd0);
        check("t6_empty",    32'(empty),     32'd1);
        check("t6_count",    32'(rd_count),  32'd0);
        check("t6_rptr",     32'(rptr_gray), 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
